// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and op classification for seq_alu.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLTU  = 4'b0010;
  localparam logic [3:0] ALU_SRL   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_OR    = 4'b0101;
  localparam logic [3:0] ALU_AND   = 4'b0110;
  localparam logic [3:0] ALU_XOR   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_MULLO = 4'b1010;
  localparam logic [3:0] ALU_MULHI = 4'b1011;
  localparam logic [3:0] ALU_DIVU  = 4'b1100;
  localparam logic [3:0] ALU_REMU  = 4'b1101;

  typedef enum logic {
    ST_IDLE,
    ST_ITER
  } aluState_t;

  function automatic logic is_iterative(input logic [3:0] op);
    case (op)
      ALU_MULLO, ALU_MULHI, ALU_DIVU, ALU_REMU: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one
// 2*WIDTH accumulator {hiReg, loReg}; one step per asserted step.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             isDiv,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [WIDTH-1:0] nextLo,
  output logic [WIDTH-1:0] nextHi
);

  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic [WIDTH-1:0] operandB;
  logic             divMode;
  logic [WIDTH:0]   addSum;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   remDiff;

  // Multiply: loReg holds the multiplier, shifted out LSB first while the
  // product's low half shifts in from the top. Divide: loReg holds the
  // dividend, shifted out MSB first while quotient bits shift in at the bottom.
  always_comb begin
    addSum   = {1'b0, hiReg} + (loReg[0] ? {1'b0, operandB} : '0);
    remShift = {hiReg, loReg[WIDTH-1]};
    remDiff  = remShift - {1'b0, operandB};
    if (divMode) begin
      if (!remDiff[WIDTH]) begin
        nextHi = remDiff[WIDTH-1:0];
        nextLo = {loReg[WIDTH-2:0], 1'b1};
      end else begin
        nextHi = remShift[WIDTH-1:0];
        nextLo = {loReg[WIDTH-2:0], 1'b0};
      end
    end else begin
      nextHi = addSum[WIDTH:1];
      nextLo = {addSum[0], loReg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hiReg    <= '0;
      loReg    <= '0;
      operandB <= '0;
      divMode  <= 1'b0;
    end else if (load) begin
      hiReg    <= '0;
      loReg    <= opA;
      operandB <= opB;
      divMode  <= isDiv;
    end else if (step) begin
      hiReg <= nextHi;
      loReg <= nextLo;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle ops complete on the accepting edge, unsigned
// MUL/DIV run WIDTH steps in alu_muldiv_iter under a two-state FSM.
module seq_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             ALUSrcB,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] InputDataA,
  input  logic [WIDTH-1:0] InputDataB,
  input  logic [WIDTH-1:0] ImmediateDataB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int               CNT_W    = SHW + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  aluState_t        state;
  aluState_t        nextState;
  logic [CNT_W-1:0] count;
  logic             selHi;
  logic [WIDTH-1:0] opB;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] singleResult;
  logic             singleOvf;
  logic [WIDTH-1:0] nextResult;
  logic             nextOvf;
  logic [WIDTH-1:0] iterLo;
  logic [WIDTH-1:0] iterHi;
  logic             load;
  logic             step;
  logic             writeEn;

  alu_muldiv_iter #(.WIDTH(WIDTH)) uMulDiv (
    .clk    (CLK),
    .reset  (Reset),
    .load   (load),
    .step   (step),
    .isDiv  (ALUOp[2]),
    .opA    (InputDataA),
    .opB    (opB),
    .nextLo (iterLo),
    .nextHi (iterHi)
  );

  always_comb begin
    opB          = ALUSrcB ? ImmediateDataB : InputDataB;
    shamt        = opB[SHW-1:0];
    sum          = InputDataA + opB;
    diff         = InputDataA - opB;
    singleResult = '0;
    singleOvf    = 1'b0;
    case (ALUOp)
      ALU_ADD: begin
        singleResult = sum;
        singleOvf    = (InputDataA[WIDTH-1] == opB[WIDTH-1]) &&
                       (sum[WIDTH-1] != InputDataA[WIDTH-1]);
      end
      ALU_SUB: begin
        singleResult = diff;
        singleOvf    = (InputDataA[WIDTH-1] != opB[WIDTH-1]) &&
                       (diff[WIDTH-1] != InputDataA[WIDTH-1]);
      end
      ALU_SLTU: singleResult = WIDTH'(InputDataA < opB);
      ALU_SRL:  singleResult = InputDataA >> shamt;
      ALU_SLL:  singleResult = InputDataA << shamt;
      ALU_OR:   singleResult = InputDataA | opB;
      ALU_AND:  singleResult = InputDataA & opB;
      ALU_XOR:  singleResult = InputDataA ^ opB;
      ALU_SLT:  singleResult = WIDTH'($signed(InputDataA) < $signed(opB));
      ALU_SRA:  singleResult = WIDTH'($signed(InputDataA) >>> shamt);
      default:  singleResult = '0;
    endcase
  end

  // The final iteration writes the accumulator's next value directly, so the
  // result lands on the same edge as the last step.
  always_comb begin
    nextState  = state;
    load       = 1'b0;
    step       = 1'b0;
    writeEn    = 1'b0;
    nextResult = singleResult;
    nextOvf    = singleOvf;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          if (is_iterative(ALUOp)) begin
            load      = 1'b1;
            nextState = ST_ITER;
          end else begin
            writeEn = 1'b1;
          end
        end
      end
      ST_ITER: begin
        step       = 1'b1;
        nextResult = selHi ? iterHi : iterLo;
        nextOvf    = 1'b0;
        if (count == CNT_W'(1)) begin
          writeEn   = 1'b1;
          nextState = ST_IDLE;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      selHi    <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state <= nextState;
      Done  <= writeEn;
      if (load) begin
        count <= CNT_INIT;
        selHi <= ALUOp[0];
      end else if (step) begin
        count <= count - CNT_W'(1);
      end
      if (writeEn) begin
        result   <= nextResult;
        zero     <= (nextResult == '0);
        overflow <= nextOvf;
      end
    end
  end

  assign Busy = (state == ST_ITER);

endmodule

// File: tb/tb_seq_alu.sv
// Directed vector bench for seq_alu (WIDTH=32): op table plus hand-written
// busy/back-to-back and mid-operation reset sequences.
module tb_seq_alu;
  import alu_pkg::*;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic        ALUSrcB;
  logic [3:0]  ALUOp;
  logic [31:0] InputDataA;
  logic [31:0] InputDataB;
  logic [31:0] ImmediateDataB;
  logic        Busy;
  logic        Done;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  int nVec = 0;
  int nErr = 0;

  seq_alu #(.WIDTH(32)) dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .Start          (Start),
    .ALUSrcB        (ALUSrcB),
    .ALUOp          (ALUOp),
    .InputDataA     (InputDataA),
    .InputDataB     (InputDataB),
    .ImmediateDataB (ImmediateDataB),
    .Busy           (Busy),
    .Done           (Done),
    .result         (result),
    .zero           (zero),
    .overflow       (overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        src;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] expR;
    logic        expZ;
    logic        expO;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start at a negedge; lat = edges after the accepting edge until Done.
  task automatic runOp(input logic [3:0] op, input logic src, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, output int lat);
    @(negedge CLK);
    ALUOp = op; ALUSrcB = src; InputDataA = a; InputDataB = b; ImmediateDataB = imm;
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    lat = 0;
    while (!Done && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int busyCnt;
    int doneCnt;

    vecs.push_back('{"add_ovf",  ALU_ADD,   1'b0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h80000000, 1'b0, 1'b1, 0});
    vecs.push_back('{"sub_zero", ALU_SUB,   1'b0, 32'h5, 32'h5, 32'h0, 32'h0, 1'b1, 1'b0, 0});
    vecs.push_back('{"sub_ovf",  ALU_SUB,   1'b0, 32'h80000000, 32'h1, 32'h0, 32'h7FFFFFFF, 1'b0, 1'b1, 0});
    vecs.push_back('{"sll_imm",  ALU_SLL,   1'b1, 32'h1, 32'hFFFF, 32'h4, 32'h10, 1'b0, 1'b0, 0});
    vecs.push_back('{"sra_wrap", ALU_SRA,   1'b0, 32'h80000000, 32'h21, 32'h0, 32'hC0000000, 1'b0, 1'b0, 0});
    vecs.push_back('{"srl",      ALU_SRL,   1'b0, 32'h80000000, 32'h1F, 32'h0, 32'h1, 1'b0, 1'b0, 0});
    vecs.push_back('{"sltu",     ALU_SLTU,  1'b0, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 1'b0, 0});
    vecs.push_back('{"slt_t",    ALU_SLT,   1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h1, 1'b0, 1'b0, 0});
    vecs.push_back('{"slt_f",    ALU_SLT,   1'b0, 32'h1, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1'b0, 0});
    vecs.push_back('{"or",       ALU_OR,    1'b0, 32'hF0F0, 32'h0F0F, 32'h0, 32'hFFFF, 1'b0, 1'b0, 0});
    vecs.push_back('{"and",      ALU_AND,   1'b1, 32'hFF00, 32'h0, 32'h0FF0, 32'h0F00, 1'b0, 1'b0, 0});
    vecs.push_back('{"xor_zero", ALU_XOR,   1'b0, 32'hA5A5, 32'hA5A5, 32'h0, 32'h0, 1'b1, 1'b0, 0});
    vecs.push_back('{"op_1110",  4'b1110,   1'b0, 32'h1234, 32'h5678, 32'h0, 32'h0, 1'b1, 1'b0, 0});
    vecs.push_back('{"mulhi",    ALU_MULHI, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 1'b0, 1'b0, 32});
    vecs.push_back('{"mullo",    ALU_MULLO, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 1'b0, 32});
    vecs.push_back('{"mullo_3x5",ALU_MULLO, 1'b1, 32'h3, 32'h0, 32'h5, 32'hF, 1'b0, 1'b0, 32});
    vecs.push_back('{"divu",     ALU_DIVU,  1'b0, 32'd100, 32'd7, 32'h0, 32'd14, 1'b0, 1'b0, 32});
    vecs.push_back('{"remu",     ALU_REMU,  1'b0, 32'd100, 32'd7, 32'h0, 32'd2, 1'b0, 1'b0, 32});
    vecs.push_back('{"divu_0",   ALU_DIVU,  1'b0, 32'd9, 32'd0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 32});
    vecs.push_back('{"remu_0",   ALU_REMU,  1'b0, 32'd9, 32'd0, 32'h0, 32'd9, 1'b0, 1'b0, 32});
    vecs.push_back('{"divu_big", ALU_DIVU,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 1'b0, 1'b0, 32});

    Reset = 1'b1; Start = 1'b0; ALUSrcB = 1'b0; ALUOp = '0;
    InputDataA = '0; InputDataB = '0; ImmediateDataB = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_result", result, 32'h0);
    check("rst_zero", {31'b0, zero}, 32'h0);
    check("rst_ovf", {31'b0, overflow}, 32'h0);
    check("rst_busy", {31'b0, Busy}, 32'h0);
    check("rst_done", {31'b0, Done}, 32'h0);
    Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      runOp(vecs[i].op, vecs[i].src, vecs[i].a, vecs[i].b, vecs[i].imm, lat);
      check({vecs[i].name, "_result"}, result, vecs[i].expR);
      check({vecs[i].name, "_zero"}, {31'b0, zero}, {31'b0, vecs[i].expZ});
      check({vecs[i].name, "_ovf"}, {31'b0, overflow}, {31'b0, vecs[i].expO});
      check({vecs[i].name, "_latency"}, lat, vecs[i].expLat);
    end

    // MULHI with Start pulsed and operands toggled while busy, then a
    // back-to-back ADD issued in the Done cycle.
    @(negedge CLK);
    ALUOp = ALU_MULHI; ALUSrcB = 1'b0; InputDataA = 32'hFFFFFFFF; InputDataB = 32'hFFFFFFFF;
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    lat = 0; busyCnt = 0;
    while (!Done && lat < 100) begin
      if (Busy) busyCnt++;
      if (lat == 5) begin Start = 1'b1; ALUOp = ALU_ADD; InputDataA = '0; InputDataB = '0; end
      if (lat == 8) Start = 1'b0;
      if (lat == 12) begin InputDataA = 32'h1234; ALUSrcB = 1'b1; ImmediateDataB = 32'h3; end
      @(posedge CLK); #1;
      lat++;
    end
    check("busy_mulhi_result", result, 32'hFFFFFFFE);
    check("busy_mulhi_latency", lat, 32);
    check("busy_cycles", busyCnt, 32);
    check("busy_low_at_done", {31'b0, Busy}, 32'h0);

    ALUOp = ALU_ADD; ALUSrcB = 1'b0; InputDataA = 32'd2; InputDataB = 32'd3;
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    check("b2b_done", {31'b0, Done}, 32'h1);
    check("b2b_result", result, 32'd5);
    @(posedge CLK); #1;
    check("done_one_cycle", {31'b0, Done}, 32'h0);
    check("result_hold", result, 32'd5);

    // Reset at iteration 10 of a DIVU aborts it without a Done.
    @(negedge CLK);
    ALUOp = ALU_DIVU; ALUSrcB = 1'b0; InputDataA = 32'd100; InputDataB = 32'd7;
    Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (10) begin @(posedge CLK); #1; end
    Reset = 1'b1;
    @(posedge CLK); #1;
    check("midrst_result", result, 32'h0);
    check("midrst_zero", {31'b0, zero}, 32'h0);
    check("midrst_ovf", {31'b0, overflow}, 32'h0);
    check("midrst_busy", {31'b0, Busy}, 32'h0);
    check("midrst_done", {31'b0, Done}, 32'h0);
    Reset = 1'b0;
    doneCnt = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (Done) doneCnt++;
    end
    check("midrst_no_done", doneCnt, 0);
    runOp(ALU_ADD, 1'b0, 32'd2, 32'd2, 32'd0, lat);
    check("post_rst_add_result", result, 32'd4);
    check("post_rst_add_latency", lat, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
